// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer and its instruction decoder.
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } seq_state_e;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_LOAD,
        PC_INC,
        PC_REL
    } pc_op_e;

    localparam logic [8:0] HALT_INST_DEF = 9'h1FF;

    // Opcode field IR[8:6] as interpreted by the decoder
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ST  = 3'd1;
    localparam logic [2:0] OP_LD  = 3'd2;
    localparam logic [2:0] OP_BR  = 3'd3;
    localparam logic [2:0] OP_NOP = 3'd4;

endpackage

// File: rtl/core_sequencer_pc_unit.sv
// Program counter register with next-PC selection: hold, load reset vector,
// increment, or add a signed relative offset (all modulo 2^PC_W).
module core_sequencer_pc_unit
    import core_sequencer_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  pc_op_e          op,
    input  logic [PC_W-1:0] offset,
    output logic [PC_W-1:0] pc
);

    localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            unique case (op)
                PC_LOAD: pc <= RESET_PC;
                PC_INC:  pc <= pc + ONE;
                PC_REL:  pc <= pc + offset;
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR.
// Optional `INSTR_COUNT_EN adds a saturating retired-instruction counter.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int                PC_W      = 10,
    parameter int                INST_W    = 9,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter logic [INST_W-1:0] HALT_INST = HALT_INST_DEF
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              Start,
    output logic [PC_W-1:0]   InstrAddr,
    input  logic [INST_W-1:0] InstrData,
    output logic [INST_W-1:0] Ir,
    input  logic              CtrlRegWrite,
    input  logic              CtrlMemWrite,
    input  logic              CtrlMemRead,
    input  logic              CtrlBranchRel,
    input  logic              BranchTaken,
    input  logic [PC_W-1:0]   BranchOffset,
    output logic              MemReq,
    input  logic              MemAck,
    output logic              MemWriteEn,
    output logic              RegWriteEn,
    output logic              Busy,
    output logic              Done,
    output logic [15:0]       InstCount
);

    seq_state_e        state_q, state_d;
    pc_op_e            pc_op;
    logic [INST_W-1:0] ir_q;
    logic              start_ok;

    assign start_ok = Start && (state_q == S_IDLE || state_q == S_HALT);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pc_op   = PC_HOLD;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start_ok) begin
                    state_d = S_FETCH;
                    pc_op   = PC_LOAD;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (ir_q == HALT_INST) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = (CtrlMemWrite || CtrlMemRead) ? S_MEM : S_WB;
            S_MEM:    if (MemAck) state_d = S_WB;
            S_WB: begin
                state_d = S_FETCH;
                pc_op   = (CtrlBranchRel && BranchTaken) ? PC_REL : PC_INC;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN)                ir_q <= '0;
        else if (state_q == S_FETCH) ir_q <= InstrData;
    end

    core_sequencer_pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (Clk),
        .rst_n  (ResetN),
        .op     (pc_op),
        .offset (BranchOffset),
        .pc     (InstrAddr)
    );

    // Decoder strobes are only let through in the phase that owns them
    assign Ir         = ir_q;
    assign MemReq     = (state_q == S_MEM);
    assign MemWriteEn = (state_q == S_MEM) && CtrlMemWrite;
    assign RegWriteEn = (state_q == S_WB) && CtrlRegWrite;
    assign Busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign Done       = (state_q == S_HALT);

`ifdef INSTR_COUNT_EN
    logic [15:0] inst_count_q;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN)
            inst_count_q <= '0;
        else if (start_ok)
            inst_count_q <= '0;
        else if (state_q == S_WB && inst_count_q != 16'hFFFF)
            inst_count_q <= inst_count_q + 16'd1;
    end

    assign InstCount = inst_count_q;
`else
    assign InstCount = '0;
`endif

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle sequencer for the custom CPU. Owns the PC and the instruction register (IR).
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Feeds the IR to the instruction decoder and gates the decoder's RegWrite/MemWrite so they fire only in the correct phase.
- Handshakes with data memory and resolves relative branches.

Parameters:
- PC_W, 10, program counter width; PC wraps modulo 2^PC_W.
- INST_W, 9, instruction width.
- RESET_PC, 0, PC loaded on Start.
- HALT_INST, 9'h1FF, IR encoding that halts the core.

Ports:
- Clk  in  1  clock.
- ResetN  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle pulse; begins execution from RESET_PC (honoured only in IDLE or HALT).
- InstrAddr  out  PC_W  instruction ROM address (= PC).
- InstrData  in  INST_W  ROM read data, combinational from InstrAddr.
- Ir  out  INST_W  latched instruction, drives the decoder.
- CtrlRegWrite  in  1  decoder RegWrite.
- CtrlMemWrite  in  1  decoder MemWrite.
- CtrlMemRead  in  1  decoder-side load indication.
- CtrlBranchRel  in  1  decoder BranchRel.
- BranchTaken  in  1  ALU branch condition (valid in EXEC through WB).
- BranchOffset  in  PC_W  signed PC-relative offset.
- MemReq  out  1  data memory request.
- MemAck  in  1  data memory completion.
- MemWriteEn  out  1  gated memory write strobe.
- RegWriteEn  out  1  gated register-file write strobe.
- Busy  out  1  high outside IDLE/HALT.
- Done  out  1  high while in HALT.
- InstCount  out  16  retired-instruction count (see Optional Feature).

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Encoded as a package enum.
- Reset (async, any state, including mid-MEM):
  - state=IDLE, PC=RESET_PC, IR=0, InstCount=0.
  - All outputs 0, except InstrAddr=RESET_PC and Ir=0.
- IDLE: Start=1 -> PC<=RESET_PC, go FETCH.
- FETCH: IR<=InstrData at the clock edge, then go DECODE. Exactly 1 cycle.
- DECODE: if IR==HALT_INST go HALT. Otherwise go EXEC. Decoder outputs are sampled from here on and are stable because IR is stable.
- EXEC: 1 cycle, for ALU settle. If CtrlMemWrite|CtrlMemRead go MEM, else go WB.
- MEM:
  - MemReq=1 for every cycle in MEM. MemWriteEn=CtrlMemWrite for every cycle in MEM.
  - Stay in MEM until MemAck=1. MemAck in the same cycle MemReq first rises is legal (1-cycle MEM).
  - Then go WB. No timeout.
- WB:
  - RegWriteEn=CtrlRegWrite, for 1 cycle.
  - If CtrlBranchRel & BranchTaken: PC<=PC+BranchOffset (two's-complement add, truncated to PC_W, wraps). Otherwise PC<=PC+1 (wraps from 2^PC_W-1 to 0).
  - Go FETCH.
- HALT: Done=1, Busy=0. Start=1 -> PC<=RESET_PC, go FETCH.
- Start outside IDLE/HALT is ignored.
- MemReq, MemWriteEn and RegWriteEn are never high outside MEM/WB respectively.
- All outputs are registered state plus combinational decode of state only, except MemWriteEn/RegWriteEn, which AND state with the Ctrl inputs.
- Latency: non-memory instruction = 4 cycles (F,D,E,W). Memory instruction = 4 + number of MEM cycles.

Optional Feature:
- Macro INSTR_COUNT_EN.
- Defined: InstCount increments by 1 on each WB exit, saturating at 16'hFFFF. It clears on reset and on an honoured Start.
- Undefined: InstCount tied to 0 and no counter flops are generated.

Decomposition:
- Shared package (existing definitions):
  - seq_state_e enum.
  - HALT_INST default constant.
  - Opcode mnemonics already used by the decoder.
- One natural sub-module: pc_unit. It holds the PC register plus next-PC logic: hold, load RESET_PC, +1, +offset.
- The FSM stays in core_sequencer.

Test Plan:
- Reset/start: hold ResetN=0, then release; pulse Start with ROM[0]=ADD-type (CtrlRegWrite=1) -> InstrAddr 0, RegWriteEn=1 exactly in cycle 4 after Start, then InstrAddr=1.
- Store with wait: CtrlMemWrite=1, MemAck delayed 3 cycles -> MemReq high 3 cycles, MemWriteEn high 3 cycles, RegWriteEn=0, next fetch at PC+1.
- Branch: PC=5, CtrlBranchRel=1, BranchTaken=1, BranchOffset=-3 -> next InstrAddr=2. Repeat with BranchTaken=0 -> next InstrAddr=6.
- Wrap: PC=1023, non-branch -> next InstrAddr=0. PC=1020, offset=+6 -> InstrAddr=2.
- Halt/restart: IR=9'h1FF -> Done=1, Busy=0 from the cycle after DECODE. Start -> Done=0, InstrAddr=RESET_PC. A Start pulse mid-EXEC has no effect.
- Async reset in MEM while MemReq=1 -> MemReq drops immediately (no clock edge), state IDLE. With INSTR_COUNT_EN, InstCount=0 after reset and equals the number of retired instructions before HALT.
